// File: rtl/match_pkg.sv
// Shared state codes, winner codes, default frame constants and win rule for the match sequencer.
// Build option MATCH_DEUCE_EN: when defined, a win also needs a 2-point lead, unless a score reaches 15.
package match_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SERVE      = 3'd1;
    localparam logic [2:0] ST_RALLY      = 3'd2;
    localparam logic [2:0] ST_POINT      = 3'd3;
    localparam logic [2:0] ST_PAUSE      = 3'd4;
    localparam logic [2:0] ST_MATCH_OVER = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam int FRAME_DIV_DEF         = 1666667;
    localparam int SERVE_HOLD_FRAMES_DEF = 60;
    localparam int POINT_HOLD_FRAMES_DEF = 90;
    localparam int WIN_SCORE_DEF         = 7;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    // True when 'me' has won against 'other' under the build's win rule.
    function automatic logic has_won(input logic [3:0] me, input logic [3:0] other,
                                     input logic [3:0] target);
`ifdef MATCH_DEUCE_EN
        return (me == 4'hF) || ((me >= target) && ({1'b0, me} >= ({1'b0, other} + 5'd2)));
`else
        return me >= target;
`endif
    endfunction

endpackage

// File: rtl/match_controller_frame_tick_gen.sv
// Free-running frame divider: counts 0..FRAME_DIV-1, registered one-cycle tick after the wrap point.
// Latency: tick is high the cycle after the counter hits FRAME_DIV-1; no backpressure, never stalls.
module frame_tick_gen #(
    parameter int FRAME_DIV = 1666667
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/match_controller.sv
// Match sequencer: frame tick, phase-gated physics enable, scoring, serve/point holds, pause, winner.
// Latency: phys_en/input_enable are combinational from registers; no backpressure. Option: MATCH_DEUCE_EN.
module match_controller
    import match_pkg::*;
#(
    parameter int FRAME_DIV         = FRAME_DIV_DEF,
    parameter int SERVE_HOLD_FRAMES = SERVE_HOLD_FRAMES_DEF,
    parameter int POINT_HOLD_FRAMES = POINT_HOLD_FRAMES_DEF,
    parameter int WIN_SCORE         = WIN_SCORE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    output logic       phys_en,
    output logic       input_enable,
    output logic       frame_tick,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [2:0] state,
    output logic [1:0] match_winner
);
    localparam int HOLD_MAX = (SERVE_HOLD_FRAMES > POINT_HOLD_FRAMES) ? SERVE_HOLD_FRAMES : POINT_HOLD_FRAMES;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] SERVE_LAST = HW'(SERVE_HOLD_FRAMES - 1);
    localparam logic [HW-1:0] POINT_LAST = HW'(POINT_HOLD_FRAMES - 1);
    localparam logic [3:0]    TARGET     = 4'(WIN_SCORE);

    logic [HW-1:0] hold_cnt;
    logic          flush_pending;
    logic [2:0]    saved_state;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (frame_tick)
    );

    assign phys_en      = frame_tick && ((state == ST_RALLY) || ((state == ST_POINT) && flush_pending));
    assign input_enable = (state == ST_RALLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            saved_state   <= ST_IDLE;
            hold_cnt      <= '0;
            flush_pending <= 1'b0;
            p1_score      <= 4'd0;
            p2_score      <= 4'd0;
            match_winner  <= WIN_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_MATCH_OVER: begin
                    if (start_pulse) begin
                        state        <= ST_SERVE;
                        hold_cnt     <= '0;
                        p1_score     <= 4'd0;
                        p2_score     <= 4'd0;
                        match_winner <= WIN_NONE;
                    end
                end
                ST_SERVE: begin
                    // A pause landing on a tick freezes the count before that tick is taken.
                    if (pause_pulse) begin
                        saved_state <= ST_SERVE;
                        state       <= ST_PAUSE;
                    end else if (frame_tick) begin
                        if (hold_cnt == SERVE_LAST) begin
                            hold_cnt <= '0;
                            state    <= ST_RALLY;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                ST_RALLY: begin
                    if (phys_game_over) begin
                        state         <= ST_POINT;
                        flush_pending <= 1'b1;
                        hold_cnt      <= '0;
                        if (phys_winner == WIN_P1)
                            p1_score <= sat_inc(p1_score);
                        else if (phys_winner == WIN_P2)
                            p2_score <= sat_inc(p2_score);
                    end else if (pause_pulse) begin
                        saved_state <= ST_RALLY;
                        state       <= ST_PAUSE;
                    end
                end
                ST_POINT: begin
                    if (frame_tick) begin
                        flush_pending <= 1'b0;
                        if (hold_cnt == POINT_LAST) begin
                            hold_cnt <= '0;
                            if (has_won(p1_score, p2_score, TARGET)) begin
                                match_winner <= WIN_P1;
                                state        <= ST_MATCH_OVER;
                            end else if (has_won(p2_score, p1_score, TARGET)) begin
                                match_winner <= WIN_P2;
                                state        <= ST_MATCH_OVER;
                            end else begin
                                state <= ST_SERVE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_pulse)
                        state <= saved_state;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Randomized and directed bench for match_controller with a frame/hold-level reference model.
module tb_match_controller;
    localparam int FD = 4;
    localparam int SH = 2;
    localparam int PH = 3;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_pulse = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       phys_game_over = 1'b0;
    logic [1:0] phys_winner = 2'd0;
    logic       phys_en, input_enable, frame_tick;
    logic [3:0] p1_score, p2_score;
    logic [2:0] state;
    logic [1:0] match_winner;

    int n_cmp = 0;
    int n_bad = 0;

    match_controller #(
        .FRAME_DIV(FD), .SERVE_HOLD_FRAMES(SH), .POINT_HOLD_FRAMES(PH), .WIN_SCORE(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .phys_game_over(phys_game_over), .phys_winner(phys_winner), .phys_en(phys_en),
        .input_enable(input_enable), .frame_tick(frame_tick), .p1_score(p1_score),
        .p2_score(p2_score), .state(state), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    // Reference model: clocks since reset, frames left in the current hold.
    int m_n, ms, m_saved, m_left, m_flush, mp1, mp2, mw;

    function automatic bit won(input int me, input int other);
`ifdef MATCH_DEUCE_EN
        return (me == 15) || (me >= WS && me - other >= 2);
`else
        return me >= WS;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0; ms = 0; m_saved = 0; m_left = 0; m_flush = 0; mp1 = 0; mp2 = 0; mw = 0;
            end else begin
                bit tk;
                tk = (m_n > 0) && (m_n % FD == 0);
                case (ms)
                    0, 5: if (start_pulse) begin
                        ms = 1; m_left = SH; mp1 = 0; mp2 = 0; mw = 0;
                    end
                    1: if (pause_pulse) begin
                        m_saved = 1; ms = 4;
                    end else if (tk) begin
                        m_left = m_left - 1;
                        if (m_left == 0) ms = 2;
                    end
                    2: if (phys_game_over) begin
                        if (phys_winner == 1 && mp1 < 15) mp1 = mp1 + 1;
                        if (phys_winner == 2 && mp2 < 15) mp2 = mp2 + 1;
                        ms = 3; m_flush = 1; m_left = PH;
                    end else if (pause_pulse) begin
                        m_saved = 2; ms = 4;
                    end
                    3: if (tk) begin
                        m_flush = 0;
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            if (won(mp1, mp2)) begin ms = 5; mw = 1; end
                            else if (won(mp2, mp1)) begin ms = 5; mw = 2; end
                            else begin ms = 1; m_left = SH; end
                        end
                    end
                    4: if (pause_pulse) ms = m_saved;
                    default: ms = 0;
                endcase
                m_n = m_n + 1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit et, ee;
                logic [16:0] got, exp;
                et = (m_n > 0) && (m_n % FD == 0);
                ee = et && (ms == 2 || (ms == 3 && m_flush != 0));
                got = {phys_en, input_enable, frame_tick, p1_score, p2_score, state, match_winner};
                exp = {ee, (ms == 2), et, 4'(mp1), 4'(mp2), 3'(ms), 2'(mw)};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL model_cmp t=%0t: got %h expected %h", $time, got, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        for (int i = 0; i < budget && state != 3'(s); i++) cyc();
        chk(name, state, s);
    endtask

    task automatic wait_leave_point();
        for (int i = 0; i < 60 && state == 3'd3; i++) cyc();
    endtask

    task automatic pulse_start();
        start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_pulse = 1'b1; cyc(); pause_pulse = 1'b0;
    endtask

    task automatic score_point(input int w);
        wait_state(2, 60, "reach_rally");
        phys_game_over = 1'b1; phys_winner = 2'(w);
        cyc();
        phys_game_over = 1'b0; phys_winner = 2'd0;
        wait_leave_point();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        #1;
        repeat (3) cyc();
        chk("reset_state", state, 0);
        chk("reset_p1", p1_score, 0);
        chk("reset_p2", p2_score, 0);
        chk("reset_winner", match_winner, 0);
        chk("reset_phys_en", phys_en, 0);
        chk("reset_tick", frame_tick, 0);
        chk("reset_input_en", input_enable, 0);
        rst_n = 1'b1;
        cyc();

        pulse_start();
        chk("start_serve", state, 1);
        wait_state(2, 20, "serve_to_rally");
        chk("rally_input_en", input_enable, 1);
        cnt = 0;
        repeat (8) begin if (phys_en) cnt++; cyc(); end
        chk("rally_phys_en_rate", cnt, 2);

        phys_game_over = 1'b1; phys_winner = 2'd2;
        cyc();
        phys_game_over = 1'b0; phys_winner = 2'd0;
        chk("p2_point_score", p2_score, 1);
        chk("p2_point_state", state, 3);
        cnt = 0;
        for (int i = 0; i < 40 && state == 3'd3; i++) begin if (phys_en) cnt++; cyc(); end
        chk("flush_phys_en_count", cnt, 1);
        chk("point_to_serve", state, 1);

        repeat (3) score_point(1);
        chk("win_p1_score", p1_score, 3);
        chk("win_state", state, 5);
        chk("win_winner", match_winner, 1);
        cnt = 0;
        repeat (12) begin if (phys_en) cnt++; cyc(); end
        chk("match_over_no_phys_en", cnt, 0);
        pause_pulse = 1'b1; pulse_start(); pause_pulse = 1'b0;
        chk("restart_p1", p1_score, 0);
        chk("restart_p2", p2_score, 0);
        chk("restart_state", state, 1);
        chk("restart_winner", match_winner, 0);

        wait_state(2, 20, "rally_before_pause");
        pulse_pause();
        chk("paused", state, 4);
        cnt = 0;
        repeat (40) begin if (phys_en) cnt++; cyc(); end
        chk("pause_no_phys_en", cnt, 0);
        chk("still_paused", state, 4);
        pulse_pause();
        chk("resume_rally", state, 2);
        cnt = 0;
        repeat (4) begin if (phys_en) cnt++; cyc(); end
        chk("resume_phys_en", cnt, 1);

        phys_game_over = 1'b1; phys_winner = 2'd0;
        cyc();
        phys_game_over = 1'b0;
        chk("invalid_win_state", state, 3);
        chk("invalid_win_p1", p1_score, 0);
        chk("invalid_win_p2", p2_score, 0);
        wait_leave_point();
        chk("invalid_win_serve", state, 1);
        wait_state(2, 20, "rally_before_tie");
        phys_game_over = 1'b1; pause_pulse = 1'b1; phys_winner = 2'd1;
        cyc();
        phys_game_over = 1'b0; pause_pulse = 1'b0; phys_winner = 2'd0;
        chk("point_beats_pause", state, 3);
        chk("point_beats_pause_p1", p1_score, 1);
        wait_leave_point();

`ifdef MATCH_DEUCE_EN
        do_reset();
        pulse_start();
        repeat (3) begin score_point(1); score_point(2); end
        chk("deuce_p1", p1_score, 3);
        chk("deuce_p2", p2_score, 3);
        score_point(1);
        chk("adv_p1", p1_score, 4);
        chk("adv_state", state, 1);
        score_point(1);
        chk("deuce_win_p1", p1_score, 5);
        chk("deuce_win_state", state, 5);
        chk("deuce_win_winner", match_winner, 1);
`endif

        // Random phase, with an asynchronous reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            start_pulse    = ($urandom % 40) == 0;
            pause_pulse    = ($urandom % 25) == 0;
            phys_game_over = ($urandom % 10) == 0;
            phys_winner    = 2'($urandom % 4);
            if (i == 2000) begin
                #2 rst_n = 1'b0;
                #10 rst_n = 1'b1;
            end
            cyc();
        end
        start_pulse = 1'b0; pause_pulse = 1'b0; phys_game_over = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Match-level sequencer for the volleyball physics engine.
- Generates the 60 Hz frame tick and gates the physics enable per match phase.
- Keeps P1/P2 scores from the physics game_over/winner pulse and holds serve/point delays.
- Supports pause; declares the match winner. Sits between the top-level button debouncers and the physics block.

Parameters:
FRAME_DIV, 1666667, clk cycles per frame tick (100 MHz / 60)
SERVE_HOLD_FRAMES, 60, frames frozen before each rally
POINT_HOLD_FRAMES, 90, frames frozen after a point, including the flush frame
WIN_SCORE, 7, points needed to win the match (4-bit scores)

Ports:
clk  in  1  system clock
rst_n  in  1  reset: asynchronous, active-low
start_pulse  in  1  one-cycle start/restart request (debounced)
pause_pulse  in  1  one-cycle pause toggle (debounced)
phys_game_over  in  1  physics point-ended flag (level until next phys_en)
phys_winner  in  2  1 = P1 scored, 2 = P2 scored, other values invalid
phys_en  out  1  one-cycle frame enable to the physics block
input_enable  out  1  high only in RALLY; top level ANDs player controls with it
frame_tick  out  1  free-running one-cycle frame pulse for video/HUD
p1_score  out  4  P1 points
p2_score  out  4  P2 points
state  out  3  current state, for HUD
match_winner  out  2  0 = none, 1 = P1, 2 = P2

Behaviour:
- Reset values: all outputs 0; state = IDLE; frame and hold counters 0.
- Frame divider:
  - Counter runs 0..FRAME_DIV-1 and wraps.
  - frame_tick is registered and high for the one cycle after the counter reaches FRAME_DIV-1.
  - The divider runs in every state, including PAUSE.
- phys_en = frame_tick AND (state == RALLY OR (state == POINT AND flush_pending)). It is combinational from registers, so it has zero latency after frame_tick.
- States: IDLE, SERVE, RALLY, POINT, PAUSE, MATCH_OVER.
- IDLE:
  - start_pulse -> SERVE with hold counter cleared.
  - Scores and match_winner are cleared at the same time.
- SERVE:
  - Count frame ticks.
  - After SERVE_HOLD_FRAMES ticks -> RALLY.
  - No phys_en in this state.
- RALLY:
  - On any cycle where phys_game_over = 1 -> POINT, with flush_pending set and hold counter cleared.
  - In the same cycle, increment p1_score if phys_winner = 1, or p2_score if phys_winner = 2.
  - Invalid winner: no score change, still -> POINT.
- POINT:
  - The first tick issues phys_en. This is the flush frame: physics resets positions and clears game_over. flush_pending is then cleared.
  - After POINT_HOLD_FRAMES ticks (flush tick counted) -> MATCH_OVER if either score >= WIN_SCORE, else -> SERVE.
  - phys_game_over is not re-sampled in POINT.
- MATCH_OVER:
  - match_winner is set on entry to the player who reached WIN_SCORE.
  - Hold until start_pulse -> clear scores and match_winner -> SERVE.
- PAUSE:
  - pause_pulse in SERVE or RALLY -> PAUSE; the prior state is saved.
  - pause_pulse in PAUSE -> return to the saved state.
  - Hold counters freeze and phys_en stays low while paused.
  - pause_pulse is ignored in IDLE, POINT and MATCH_OVER.
- Simultaneous events:
  - phys_game_over and pause_pulse in the same RALLY cycle: the point is taken and the pause is dropped.
  - start_pulse outside IDLE/MATCH_OVER is ignored.
  - pause_pulse and start_pulse together in MATCH_OVER: start wins.
- Score saturation: scores saturate at 15 and never wrap.
- Reset mid-operation: returns immediately to reset values. Physics has its own reset on the same rst_n.

Optional Feature:
- Macro: MATCH_DEUCE_EN.
- Defined: win requires score >= WIN_SCORE and a lead of >= 2 over the opponent, or either score reaching 15.
- Undefined: first to WIN_SCORE wins; the lead is ignored.
- The win check is evaluated only at the end of POINT in both builds.

Decomposition:
- Package match_pkg holds:
  - the state enum (3-bit encoding: IDLE = 0, SERVE = 1, RALLY = 2, POINT = 3, PAUSE = 4, MATCH_OVER = 5);
  - winner codes WIN_NONE = 0, WIN_P1 = 1, WIN_P2 = 2;
  - the default frame constants.
- One sub-module: frame_tick_gen (FRAME_DIV counter plus registered tick), reusable by the video side.

Test Plan (FRAME_DIV=4, SERVE_HOLD_FRAMES=2, POINT_HOLD_FRAMES=3, WIN_SCORE=3):
- Reset, then start_pulse -> state SERVE; after 2 ticks state RALLY; phys_en pulses once every 4 clocks; input_enable = 1.
- In RALLY, hold phys_game_over = 1 with phys_winner = 2 -> next cycle p2_score = 1 and state POINT; exactly one phys_en on the next tick; after 3 ticks state SERVE.
- Three P1 points -> p1_score = 3, state MATCH_OVER, match_winner = 1, phys_en stays 0; start_pulse -> scores 0, state SERVE.
- pause_pulse in RALLY -> PAUSE with no phys_en for 10 ticks; second pause_pulse -> RALLY; phys_en resumes on the next tick.
- phys_game_over with phys_winner = 0 -> no score change, state POINT then SERVE; phys_game_over and pause_pulse in the same cycle -> POINT, not PAUSE.
- With MATCH_DEUCE_EN defined, reach 3-3 then a P1 point -> 4-3 and state SERVE; next P1 point -> 5-3 and state MATCH_OVER with match_winner = 1.
